lzs_src_unpack: RTL and testbench

Input stage of the LZS encoder. Pops 64-bit words from the source FIFO, serializes them little-endian into a byte stream with a valid/ready handshake, trims the final word to the byte count `fi_cnt`, and consumes the end-of-stream marker word (`m_last`). It sits between the source FIFO/memory pair and the byte-wide compressor core.

---
 rtl/lzs_src_unpack_pkg.sv | 14 +
 rtl/lzs_byte_shifter.sv | 71 +++++++
 rtl/lzs_src_unpack.sv | 106 ++++++++++
 tb/tb_lzs_src_unpack.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lzs_src_unpack_pkg.sv
// rtl/lzs_src_unpack_pkg.sv - shared state encoding and word geometry for the LZS source unpacker
package lzs_src_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_BYTES = 8;
  localparam int NB_W       = 4;

endpackage

// File: rtl/lzs_byte_shifter.sv
// rtl/lzs_byte_shifter.sv - 64-bit word to byte shifter with a one-word prefetch slot
module lzs_byte_shifter
  import lzs_src_unpack_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            accept_i,
  input  logic            load_i,
  input  logic [63:0]     word_i,
  output logic [7:0]      byte_o,
  output logic [NB_W-1:0] nb_o,
  output logic [NB_W-1:0] nb_next_o,
  output logic            pf_v_next_o
);

  logic [63:0]     sh_q, sh_d;
  logic [63:0]     pf_q, pf_d;
  logic [NB_W-1:0] nb_q, nb_d;
  logic            pf_v_q, pf_v_d;

  always_comb begin
    sh_d   = sh_q;
    nb_d   = nb_q;
    pf_d   = pf_q;
    pf_v_d = pf_v_q;
    if (accept_i) begin
      sh_d = sh_q >> 8;
      nb_d = nb_q - NB_W'(1);
    end
    // A returning word goes straight to sh when sh empties this cycle, so words abut without a bubble.
    if (load_i) begin
      if (nb_d == '0) begin
        sh_d = word_i;
        nb_d = NB_W'(WORD_BYTES);
      end else begin
        pf_d   = word_i;
        pf_v_d = 1'b1;
      end
    end else if (nb_d == '0 && pf_v_q) begin
      sh_d   = pf_q;
      nb_d   = NB_W'(WORD_BYTES);
      pf_v_d = 1'b0;
    end
    if (clr_i) begin
      nb_d   = '0;
      pf_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      pf_q   <= '0;
      nb_q   <= '0;
      pf_v_q <= 1'b0;
    end else if (en_i) begin
      sh_q   <= sh_d;
      pf_q   <= pf_d;
      nb_q   <= nb_d;
      pf_v_q <= pf_v_d;
    end
  end

  assign byte_o      = sh_q[7:0];
  assign nb_o        = nb_q;
  assign nb_next_o   = nb_d;
  assign pf_v_next_o = pf_v_d;

endmodule

// File: rtl/lzs_src_unpack.sv
// rtl/lzs_src_unpack.sv - pops 64-bit source words and streams them out as trimmed little-endian bytes
module lzs_src_unpack
  import lzs_src_unpack_pkg::*;
#(
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [LZF_WIDTH-1:0] fi_cnt,
  input  logic                 src_empty,
  input  logic [63:0]          fi,
  input  logic                 m_last,
  output logic                 m_src_getn,
  output logic [7:0]           byte_o,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 done,
  output logic                 err
);

  state_e               state_q;
  logic [LZF_WIDTH-1:0] remain_q, remain_d;
  logic                 pend_q, done_q, err_q;

  logic [NB_W-1:0]      nb, nb_next;
  logic                 pf_v_next;
  logic                 run, drain, accept, ret, ret_mark, ret_data;
  logic                 to_drain, held_ok, pop;

  assign run      = (state_q == RUN);
  assign drain    = (state_q == DRAIN);
  assign accept   = ce && byte_valid && byte_ready;
  assign ret      = ce && pend_q;
  assign ret_mark = ret && m_last;
  assign ret_data = ret && !m_last && run && !err_q;

  assign remain_d = (accept && remain_q != '0) ? remain_q - LZF_WIDTH'(1) : remain_q;
  assign to_drain = run && !err_q && !ret_mark && (remain_d == '0);
  // Only fetch another data word while the stream still needs bytes beyond what sh will hold.
  assign held_ok  = remain_d > {{(LZF_WIDTH-NB_W){1'b0}}, nb_next};
  assign pop      = ce && !src_empty && !pend_q && !pf_v_next &&
                    ((run && !err_q && held_ok) || drain);

  lzs_byte_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .en_i        (ce),
    .clr_i       (to_drain),
    .accept_i    (accept),
    .load_i      (ret_data),
    .word_i      (fi),
    .byte_o      (byte_o),
    .nb_o        (nb),
    .nb_next_o   (nb_next),
    .pf_v_next_o (pf_v_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ce) begin
        pend_q <= pop;
        unique case (state_q)
          IDLE: begin
            remain_q <= fi_cnt;
            state_q  <= RUN;
          end
          RUN: begin
            remain_q <= remain_d;
            if (ret_mark) err_q <= 1'b1;
            // An early marker lets the held bytes flush before finishing.
            if ((ret_mark || err_q) && nb_next == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (to_drain) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (ret_mark) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_src_getn = !pop;
  assign byte_valid = run && (nb != '0);
  assign byte_last  = byte_valid &&
                      ((remain_q == LZF_WIDTH'(1)) || (err_q && nb == NB_W'(1)));
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lzs_src_unpack.sv
// tb/tb_lzs_src_unpack.sv - directed bench for lzs_src_unpack with a one-cycle-latency FIFO model
module tb_lzs_src_unpack;
  import lzs_src_unpack_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ce, src_empty, byte_ready;
  logic [19:0] fi_cnt;
  logic [63:0] fi = '0;
  logic        m_last = 1'b0;
  logic        m_src_getn, byte_valid, byte_last, done, err;
  logic [7:0]  byte_o;

  lzs_src_unpack #(.LZF_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .ce(ce), .fi_cnt(fi_cnt), .src_empty(src_empty),
    .fi(fi), .m_last(m_last), .m_src_getn(m_src_getn), .byte_o(byte_o),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] fq_d[$];
  bit          fq_m[$];
  int          rp = 0, npops = 0, empty_pops = 0;
  bit          pop_seen, ret_mark_now = 1'b0;

  // FIFO: a pop seen at an edge presents its word for the following cycle.
  always @(posedge clk) begin
    pop_seen = !m_src_getn && !rst;
    if (!m_src_getn && src_empty && !rst) empty_pops++;
    if (rst) begin
      rp = 0; npops = 0; empty_pops = 0;
    end
    #1;
    ret_mark_now = 1'b0;
    if (pop_seen) begin
      npops++;
      if (rp < fq_d.size()) begin
        fi = fq_d[rp]; m_last = fq_m[rp]; rp++;
      end else begin
        fi = '0; m_last = 1'b0;
      end
      ret_mark_now = m_last;
    end else begin
      fi = {$urandom, $urandom}; m_last = 1'b0;
    end
  end

  logic [7:0] rx_b[$];
  bit         rx_l[$];
  int         rx_c[$];
  int         ndone = 0, done_cyc = 0, mark_cyc = 0, nvalid = 0, stall_viol = 0;
  bit         stall_q = 1'b0;
  logic [7:0] stall_byte = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_b.delete(); rx_l.delete(); rx_c.delete();
      ndone = 0; nvalid = 0; stall_viol = 0; stall_q = 1'b0;
    end else begin
      if (byte_valid) nvalid++;
      if (stall_q && !(byte_valid && byte_o === stall_byte)) stall_viol++;
      stall_q    = byte_valid && !byte_ready;
      stall_byte = byte_o;
      if (byte_valid && byte_ready && ce) begin
        rx_b.push_back(byte_o); rx_l.push_back(byte_last); rx_c.push_back(cyc);
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (ret_mark_now) mark_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int b);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(b + k);
    return w;
  endfunction

  task automatic load_fifo(input int nwords);
    fq_d.delete(); fq_m.delete();
    for (int w = 0; w < nwords; w++) begin
      fq_d.push_back(mkword(8 * w)); fq_m.push_back(1'b0);
    end
    fq_d.push_back(64'hFFFF_FFFF_FFFF_FFFF); fq_m.push_back(1'b1);
  endtask

  int ce_cyc = 0;

  task automatic start(input int cnt);
    rst = 1'b1; ce = 1'b0; byte_ready = 1'b1; src_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fi_cnt = 20'(cnt); rst = 1'b0; ce = 1'b1; ce_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 300 && ndone == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done pulses"}, ndone, 1);
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, " byte count"}, rx_b.size(), n);
    for (int i = 0; i < rx_b.size(); i++) begin
      check($sformatf("%s byte%0d", tag, i), rx_b[i], i);
      check($sformatf("%s last%0d", tag, i), rx_l[i], (i == n - 1));
    end
  endtask

  bit found;

  initial begin
    rst = 1'b1; ce = 1'b0; src_empty = 1'b0; byte_ready = 1'b1; fi_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst getn", m_src_getn, 1);
    check("rst byte_o", byte_o, 0);
    check("rst valid", byte_valid, 0);
    check("rst last", byte_last, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);

    // 16 bytes, two full words
    load_fifo(2);
    start(16);
    wait_done("t1");
    check_stream("t1", 16);
    check("t1 first valid cycle", rx_c[0], ce_cyc + 3);
    check("t1 back-to-back span", rx_c[15] - rx_c[0], 15);
    check("t1 pops", npops, 3);
    check("t1 done latency", done_cyc, mark_cyc + 1);
    check("t1 err", err, 0);

    // 11 bytes: tail of second word trimmed
    load_fifo(2);
    start(11);
    wait_done("t2");
    check_stream("t2", 11);
    check("t2 pops", npops, 3);
    check("t2 err", err, 0);

    // empty stream
    load_fifo(0);
    start(0);
    wait_done("t3");
    check("t3 valid cycles", nvalid, 0);
    check("t3 pops", npops, 1);
    check("t3 done latency", done_cyc, mark_cyc + 1);
    check("t3 err", err, 0);

    // early marker: count 24 but only one data word
    load_fifo(1);
    start(24);
    wait_done("t4");
    check_stream("t4", 8);
    check("t4 pops", npops, 2);
    check("t4 err", err, 1);

    // 64 bytes with backpressure and source stalls
    load_fifo(8);
    start(64);
    for (int k = 0; k < 1500 && ndone == 0; k++) begin
      @(posedge clk);
      #1;
      byte_ready = ((k % 5) != 2) && ((k % 11) < 8);
      src_empty  = (k >= 15 && k < 35) || (k % 9 == 4);
    end
    byte_ready = 1'b1; src_empty = 1'b0;
    wait_done("t5");
    check_stream("t5", 64);
    check("t5 stall stability", stall_viol, 0);
    check("t5 pops while empty", empty_pops, 0);
    check("t5 err", err, 0);

    // reset in the middle of a stream
    load_fifo(2);
    start(16);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (byte_valid && byte_o == 8'h05) found = 1'b1;
    end
    check("t6 reached byte5", found, 1);
    rst = 1'b1; ce = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6 getn", m_src_getn, 1);
    check("t6 byte_o", byte_o, 0);
    check("t6 valid", byte_valid, 0);
    check("t6 last", byte_last, 0);
    check("t6 done", done, 0);
    check("t6 err", err, 0);
    check("t6 state", dut.state_q, IDLE);
    repeat (3) @(posedge clk);
    #1;
    check("t6 idle valid", byte_valid, 0);
    check("t6 idle getn", m_src_getn, 1);
    check("t6 idle state", dut.state_q, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
